// File: rtl/fetch_stage.sv
// fetch_stage: single-issue instruction fetch with two-word li handling,
// redirect/flush from execute, a valid/ready output bundle and a sys halt.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] out_ir,
  output logic        out_has_imm,
  output logic [15:0] out_imm,
  output logic [15:0] out_pc,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    FETCH_IMM = 2'd1,
    HALTED    = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] li_ir;
  logic [15:0] li_pc;

  logic slot_free;
  logic is_li;
  logic is_sys;

  // The output register can take a new bundle when it is empty or being drained.
  assign slot_free = !out_valid || out_ready;
  assign is_li     = (imem_data[15:12] == 4'b1111);
  assign is_sys    = (imem_data[15:12] == 4'b1110) && (imem_data[5:0] == 6'b000000);
  assign imem_addr = pc;

  // Fetch sequencer: reset, then halt hold, then redirect flush, then li/normal fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      li_ir       <= 16'h0000;
      li_pc       <= 16'h0000;
      out_valid   <= 1'b0;
      out_ir      <= 16'h0000;
      out_imm     <= 16'h0000;
      out_has_imm <= 1'b0;
      out_pc      <= 16'h0000;
      halted      <= 1'b0;
    end else begin
      case (state)
        HALTED: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end

        FETCH_IMM: begin
          if (redirect_valid) begin
            pc        <= redirect_pc;
            out_valid <= 1'b0;
            state     <= FETCH;
          end else begin
            out_ir      <= li_ir;
            out_pc      <= li_pc;
            out_imm     <= imem_data;
            out_has_imm <= 1'b1;
            out_valid   <= 1'b1;
            pc          <= pc + 16'd1;
            state       <= FETCH;
          end
        end

        default: begin
          if (redirect_valid) begin
            pc        <= redirect_pc;
            out_valid <= 1'b0;
            state     <= FETCH;
          end else if (slot_free) begin
            pc <= pc + 16'd1;
            if (is_li) begin
              li_ir     <= imem_data;
              li_pc     <= pc;
              out_valid <= 1'b0;
              state     <= FETCH_IMM;
            end else begin
              out_ir      <= imem_data;
              out_pc      <= pc;
              out_imm     <= 16'h0000;
              out_has_imm <= 1'b0;
              out_valid   <= 1'b1;
              if (is_sys) begin
                halted <= 1'b1;
                state  <= HALTED;
              end else begin
                state <= FETCH;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table, hand-written corner sequences and a
// randomized run against a bundle-level reference model of the fetch stage.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_ir;
  logic        out_has_imm;
  logic [15:0] out_imm;
  logic [15:0] out_pc;
  logic        halted;

  logic [15:0] mem [0:65535];

  int n_compared;
  int n_mismatched;

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_ir         (out_ir),
    .out_has_imm    (out_has_imm),
    .out_imm        (out_imm),
    .out_pc         (out_pc),
    .halted         (halted)
  );

  // Instruction memory answers combinationally, like a register-file ROM.
  assign imem_data = mem[imem_addr];

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        rv;
    logic [15:0] rpc;
    logic        rdy;
    logic        e_valid;
    logic [15:0] e_addr;
    logic [15:0] e_ir;
    logic [15:0] e_pc;
    logic        e_has;
    logic [15:0] e_imm;
    logic        e_halted;
    logic        e_full;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(logic rst, logic rv, logic [15:0] rpc, logic rdy,
                              logic ev, logic [15:0] ea, logic [15:0] eir,
                              logic [15:0] epc, logic eh, logic [15:0] eimm,
                              logic ehalt, logic efull);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.e_valid = ev; v.e_addr = ea; v.e_ir = eir; v.e_pc = epc;
    v.e_has = eh; v.e_imm = eimm; v.e_halted = ehalt; v.e_full = efull;
    return v;
  endfunction

  // Bundle-level reference model state
  logic        m_valid;
  logic [15:0] m_pc;
  logic [15:0] m_ir;
  logic [15:0] m_bpc;
  logic        m_has;
  logic [15:0] m_imm;
  logic        m_halted;
  logic        m_li_pending;
  logic [15:0] m_li_word;
  logic [15:0] m_li_addr;

  task automatic applyStimulus(input logic rst, input logic rv,
                               input logic [15:0] rpc, input logic rdy);
    reset          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkBundle(input string tag, input logic ev, input logic [15:0] ea,
                             input logic [15:0] eir, input logic [15:0] epc,
                             input logic eh, input logic [15:0] eimm,
                             input logic ehalt, input logic efull);
    checkOutput({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, ev});
    checkOutput({tag, ".halted"}, {15'd0, halted}, {15'd0, ehalt});
    checkOutput({tag, ".imem_addr"}, imem_addr, ea);
    if (ev || efull) begin
      checkOutput({tag, ".out_ir"}, out_ir, eir);
      checkOutput({tag, ".out_pc"}, out_pc, epc);
      checkOutput({tag, ".out_has_imm"}, {15'd0, out_has_imm}, {15'd0, eh});
      checkOutput({tag, ".out_imm"}, out_imm, eimm);
    end
  endtask

  // One clock of the reference model, driven by the inputs about to be applied.
  task automatic modelStep(input logic rst, input logic rv,
                           input logic [15:0] rpc, input logic rdy);
    logic [15:0] w;
    if (rst) begin
      m_valid = 0; m_pc = 16'h0000; m_ir = 0; m_bpc = 0; m_has = 0; m_imm = 0;
      m_halted = 0; m_li_pending = 0; m_li_word = 0; m_li_addr = 0;
    end else if (m_halted) begin
      if (m_valid && rdy) m_valid = 0;
    end else if (rv) begin
      m_pc = rpc; m_valid = 0; m_li_pending = 0;
    end else if (m_li_pending) begin
      m_ir = m_li_word; m_bpc = m_li_addr; m_imm = mem[m_pc]; m_has = 1;
      m_valid = 1; m_pc = m_pc + 16'd1; m_li_pending = 0;
    end else if (!m_valid || rdy) begin
      w = mem[m_pc];
      if (w[15:12] == 4'hF) begin
        m_li_pending = 1; m_li_word = w; m_li_addr = m_pc; m_valid = 0;
      end else begin
        m_ir = w; m_bpc = m_pc; m_imm = 0; m_has = 0; m_valid = 1;
        if (w[15:12] == 4'hE && w[5:0] == 6'd0) m_halted = 1;
      end
      m_pc = m_pc + 16'd1;
    end
  endtask

  initial begin
    logic        r_rst, r_rv, r_rdy;
    logic [15:0] r_rpc;
    logic [15:0] w;
    n_compared     = 0;
    n_mismatched   = 0;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    out_ready      = 1'b1;

    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[0] = 16'h0041; mem[1] = 16'h4082; mem[2] = 16'hF040; mem[3] = 16'h1234;
    mem[4] = 16'h2105; mem[5] = 16'h3003; mem[6] = 16'h4004; mem[7] = 16'hE000;
    mem[16'h0020] = 16'hABCD; mem[16'h0030] = 16'hF111; mem[16'h0031] = 16'h5555;

    //             rst rv rpc       rdy  valid addr      ir        pc        has imm       halt full
    vecs[0]  = mk(1, 0, 16'h0000, 1,   0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 0, 1);
    vecs[1]  = mk(1, 0, 16'h0000, 1,   0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 0, 1);
    vecs[2]  = mk(0, 0, 16'h0000, 1,   1, 16'h0001, 16'h0041, 16'h0000, 0, 16'h0000, 0, 0);
    vecs[3]  = mk(0, 0, 16'h0000, 1,   1, 16'h0002, 16'h4082, 16'h0001, 0, 16'h0000, 0, 0);
    vecs[4]  = mk(0, 0, 16'h0000, 1,   0, 16'h0003, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0);
    vecs[5]  = mk(0, 0, 16'h0000, 1,   1, 16'h0004, 16'hF040, 16'h0002, 1, 16'h1234, 0, 0);
    vecs[6]  = mk(0, 0, 16'h0000, 1,   1, 16'h0005, 16'h2105, 16'h0004, 0, 16'h0000, 0, 0);
    vecs[7]  = mk(0, 0, 16'h0000, 1,   1, 16'h0006, 16'h3003, 16'h0005, 0, 16'h0000, 0, 0);
    vecs[8]  = mk(0, 0, 16'h0000, 0,   1, 16'h0006, 16'h3003, 16'h0005, 0, 16'h0000, 0, 0);
    vecs[9]  = mk(0, 0, 16'h0000, 0,   1, 16'h0006, 16'h3003, 16'h0005, 0, 16'h0000, 0, 0);
    vecs[10] = mk(0, 0, 16'h0000, 0,   1, 16'h0006, 16'h3003, 16'h0005, 0, 16'h0000, 0, 0);
    vecs[11] = mk(0, 0, 16'h0000, 1,   1, 16'h0007, 16'h4004, 16'h0006, 0, 16'h0000, 0, 0);
    vecs[12] = mk(0, 0, 16'h0000, 1,   1, 16'h0008, 16'hE000, 16'h0007, 0, 16'h0000, 1, 0);
    vecs[13] = mk(0, 0, 16'h0000, 0,   1, 16'h0008, 16'hE000, 16'h0007, 0, 16'h0000, 1, 0);
    vecs[14] = mk(0, 1, 16'h0020, 0,   1, 16'h0008, 16'hE000, 16'h0007, 0, 16'h0000, 1, 0);
    vecs[15] = mk(0, 0, 16'h0000, 1,   0, 16'h0008, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0);
    vecs[16] = mk(0, 1, 16'h0020, 1,   0, 16'h0008, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0);
    vecs[17] = mk(1, 0, 16'h0000, 1,   0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 0, 1);

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
      checkBundle($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_addr, vecs[i].e_ir,
                  vecs[i].e_pc, vecs[i].e_has, vecs[i].e_imm, vecs[i].e_halted,
                  vecs[i].e_full);
    end

    // Redirect while the li immediate is still outstanding drops the li.
    applyStimulus(0, 1, 16'h0030, 1);
    checkBundle("redir.a", 0, 16'h0030, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 16'h0000, 1);
    checkBundle("redir.b", 0, 16'h0031, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 16'h0020, 1);
    checkBundle("redir.c", 0, 16'h0020, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 16'h0000, 1);
    checkBundle("redir.d", 1, 16'h0021, 16'hABCD, 16'h0020, 0, 16'h0000, 0, 0);

    // Reset while the li immediate is outstanding yields no li bundle.
    applyStimulus(0, 1, 16'h0030, 1);
    checkBundle("rstli.a", 0, 16'h0030, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 16'h0000, 1);
    checkBundle("rstli.b", 0, 16'h0031, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 16'h0000, 1);
    checkBundle("rstli.c", 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 0, 1);
    applyStimulus(0, 0, 16'h0000, 1);
    checkBundle("rstli.d", 1, 16'h0001, 16'h0041, 16'h0000, 0, 16'h0000, 0, 0);

    // li at the top of memory takes its immediate from address 0.
    mem[0] = 16'h00AA;
    mem[16'hFFFF] = 16'hF022;
    applyStimulus(0, 1, 16'hFFFF, 1);
    checkBundle("wrap.a", 0, 16'hFFFF, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 16'h0000, 1);
    checkBundle("wrap.b", 0, 16'h0000, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 16'h0000, 1);
    checkBundle("wrap.c", 1, 16'h0001, 16'hF022, 16'hFFFF, 1, 16'h00AA, 0, 0);
    applyStimulus(0, 0, 16'h0000, 1);
    checkBundle("wrap.d", 1, 16'h0002, 16'h4082, 16'h0001, 0, 16'h0000, 0, 0);

    // Randomized run against the reference model.
    for (int i = 0; i < 65536; i++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 40) == 0) w = {4'hE, 6'($urandom), 6'd0};
      mem[i] = w;
    end
    modelStep(1, 0, 16'h0000, 1);
    applyStimulus(1, 0, 16'h0000, 1);
    for (int c = 0; c < 3000; c++) begin
      r_rst = ($urandom_range(0, 99) == 0) || (m_halted && $urandom_range(0, 9) == 0);
      r_rv  = ($urandom_range(0, 19) == 0);
      r_rpc = 16'($urandom);
      r_rdy = ($urandom_range(0, 9) < 7);
      modelStep(r_rst, r_rv, r_rpc, r_rdy);
      applyStimulus(r_rst, r_rv, r_rpc, r_rdy);
      checkBundle($sformatf("rnd%0d", c), m_valid, m_pc, m_ir, m_bpc, m_has, m_imm,
                  m_halted, r_rst);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
